// File: rtl/decryption_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// decryption_cfg_sequencer_if
// Groups the job descriptor handshake, the datapath busy flag, the register
// access bus and the job status outputs of decryption_cfg_sequencer.
//   master : sequencer view (drives job_ready, bus strobes/address/data, status)
//   slave  : host/register-file view (drives job descriptor, dec_busy, bus reply)
// -----------------------------------------------------------------------------
interface decryption_cfg_sequencer_if #(
    parameter int addr_witdth = 8,
    parameter int reg_width   = 16
);
    // job descriptor handshake
    logic                   job_valid;
    logic                   job_ready;
    logic [1:0]             job_alg;
    logic [reg_width-1:0]   job_key;
    logic                   dec_busy;
    // register access bus
    logic [addr_witdth-1:0] addr;
    logic                   read;
    logic                   write;
    logic [reg_width-1:0]   wdata;
    logic [reg_width-1:0]   rdata;
    logic                   done;
    logic                   error;
    // job status
    logic                   cfg_done;
    logic                   cfg_err;
    logic [1:0]             err_code;

    modport master (
        input  job_valid, job_alg, job_key, dec_busy, rdata, done, error,
        output job_ready, addr, read, write, wdata, cfg_done, cfg_err, err_code
    );

    modport slave (
        output job_valid, job_alg, job_key, dec_busy, rdata, done, error,
        input  job_ready, addr, read, write, wdata, cfg_done, cfg_err, err_code
    );
endinterface

// File: rtl/decryption_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// decryption_cfg_sequencer
// Job-level controller in front of the decryption register file. Accepts one
// job (algorithm + key), waits for the datapath to drain, writes the key
// register, then the select register, optionally reads the key back, and
// reports success or a coded failure.
//
// Ports:
//   clk_sys : system clock
//   rst_n   : asynchronous active-low reset
//   bus     : decryption_cfg_sequencer_if.master (job handshake, dec_busy,
//             register bus addr/read/write/wdata/rdata/done/error,
//             cfg_done/cfg_err/err_code status)
//
// Build option:
//   READBACK_VERIFY_EN : when defined, the key is read back after the select
//                        write and compared (err_code 3 on mismatch). When
//                        undefined, read is tied low and success is reported
//                        straight after the select write completes.
//
// err_code: 1 = illegal algorithm, 2 = bus error or timeout, 3 = readback
// mismatch. It is cleared on job accept and held until the next accept.
// All outputs are registered and change in step with the state register.
// -----------------------------------------------------------------------------
module decryption_cfg_sequencer #(
    parameter int                     addr_witdth      = 8,
    parameter int                     reg_width        = 16,
    parameter logic [addr_witdth-1:0] SELECT_ADDR      = 8'h00,
    parameter logic [addr_witdth-1:0] CAESAR_KEY_ADDR  = 8'h10,
    parameter logic [addr_witdth-1:0] SCYTALE_KEY_ADDR = 8'h12,
    parameter logic [addr_witdth-1:0] ZIGZAG_KEY_ADDR  = 8'h14,
    parameter int                     TIMEOUT          = 16
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    decryption_cfg_sequencer_if.master bus
);

    localparam int                TMO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DRAIN    = 4'd1,
        WR_KEY   = 4'd2,
        WAIT_KEY = 4'd3,
        WR_SEL   = 4'd4,
        WAIT_SEL = 4'd5,
        RD_KEY   = 4'd6,
        WAIT_RD  = 4'd7,
        REPORT   = 4'd8
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [1:0]             alg_r;
    logic [reg_width-1:0]   key_r;
    logic [TMO_W-1:0]       tmo_r;
    logic [1:0]             fail_code_s;
    logic                   accept_s, tmo_hit_s, report_entry_s;

    logic                   job_ready_r, read_r, write_r, cfg_done_r, cfg_err_r;
    logic [addr_witdth-1:0] addr_r;
    logic [reg_width-1:0]   wdata_r;
    logic [1:0]             err_code_r;

    logic                   job_ready_nxt_s, read_nxt_s, write_nxt_s;
    logic                   cfg_done_nxt_s, cfg_err_nxt_s;
    logic [addr_witdth-1:0] addr_nxt_s;
    logic [reg_width-1:0]   wdata_nxt_s;
    logic [1:0]             err_code_nxt_s;

    // Key register address for a given algorithm code.
    function automatic logic [addr_witdth-1:0] key_addr_f(input logic [1:0] alg);
        logic [addr_witdth-1:0] a;
        case (alg)
            2'd0:    a = CAESAR_KEY_ADDR;
            2'd1:    a = SCYTALE_KEY_ADDR;
            2'd2:    a = ZIGZAG_KEY_ADDR;
            default: a = {addr_witdth{1'b0}};
        endcase
        return a;
    endfunction

    // job_ready_r is high exactly while the FSM sits in IDLE
    assign accept_s  = bus.job_valid & job_ready_r;
    assign tmo_hit_s = (tmo_r == TMO_LAST);

    // State register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the job descriptor on accept.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            alg_r <= 2'd0;
            key_r <= {reg_width{1'b0}};
        end else if (accept_s) begin
            alg_r <= bus.job_alg;
            key_r <= bus.job_key;
        end else begin
            alg_r <= alg_r;
            key_r <= key_r;
        end
    end

    // Wait-cycle counter: cleared on every strobe, counts in wait states.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tmo_r <= {TMO_W{1'b0}};
        end else begin
            case (state_r)
                WAIT_KEY, WAIT_SEL, WAIT_RD: tmo_r <= tmo_hit_s ? tmo_r : tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                default:                     tmo_r <= {TMO_W{1'b0}};
            endcase
        end
    end

    // Next-state logic; fail_code_s carries the outcome when moving to REPORT.
    always_comb begin
        state_nxt_s = state_r;
        fail_code_s = 2'd0;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = DRAIN;
                else          state_nxt_s = IDLE;
            end
            DRAIN: begin
                // an illegal algorithm is rejected without waiting for the drain
                if (alg_r == 2'd3) begin
                    state_nxt_s = REPORT;
                    fail_code_s = 2'd1;
                end else if (!bus.dec_busy) begin
                    state_nxt_s = WR_KEY;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            WR_KEY: state_nxt_s = WAIT_KEY;
            WR_SEL: state_nxt_s = WAIT_SEL;
            RD_KEY: state_nxt_s = WAIT_RD;
            WAIT_KEY, WAIT_SEL, WAIT_RD: begin
                if (bus.done && bus.error) begin
                    state_nxt_s = REPORT;
                    fail_code_s = 2'd2;
                end else if (bus.done) begin
                    if (state_r == WAIT_KEY) begin
                        state_nxt_s = WR_SEL;
`ifdef READBACK_VERIFY_EN
                    end else if (state_r == WAIT_SEL) begin
                        state_nxt_s = RD_KEY;
                    end else begin
                        state_nxt_s = REPORT;
                        fail_code_s = (bus.rdata != key_r) ? 2'd3 : 2'd0;
                    end
`else
                    end else begin
                        state_nxt_s = REPORT;
                    end
`endif
                end else if (tmo_hit_s) begin
                    state_nxt_s = REPORT;
                    fail_code_s = 2'd2;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            REPORT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

`ifndef READBACK_VERIFY_EN
    logic unused_rdata_s;
    assign unused_rdata_s = ^bus.rdata;
`endif

    assign report_entry_s = (state_nxt_s == REPORT) && (state_r != REPORT);

    // Output decode from the next state so registered outputs align with state_r.
    always_comb begin
        job_ready_nxt_s = (state_nxt_s == IDLE);
        write_nxt_s     = (state_nxt_s == WR_KEY) || (state_nxt_s == WR_SEL);
`ifdef READBACK_VERIFY_EN
        read_nxt_s      = (state_nxt_s == RD_KEY);
`else
        read_nxt_s      = 1'b0;
`endif
        addr_nxt_s      = addr_r;
        wdata_nxt_s     = wdata_r;
        case (state_nxt_s)
            WR_KEY: begin
                addr_nxt_s  = key_addr_f(alg_r);
                wdata_nxt_s = key_r;
            end
            WR_SEL: begin
                addr_nxt_s  = SELECT_ADDR;
                wdata_nxt_s = {{(reg_width-2){1'b0}}, alg_r};
            end
            RD_KEY: begin
                addr_nxt_s  = key_addr_f(alg_r);
            end
            default: begin
                addr_nxt_s  = addr_r;
                wdata_nxt_s = wdata_r;
            end
        endcase
        cfg_done_nxt_s = report_entry_s && (fail_code_s == 2'd0);
        cfg_err_nxt_s  = report_entry_s && (fail_code_s != 2'd0);
        if (accept_s) begin
            err_code_nxt_s = 2'd0;
        end else if (report_entry_s) begin
            err_code_nxt_s = fail_code_s;
        end else begin
            err_code_nxt_s = err_code_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            job_ready_r <= 1'b1;
            addr_r      <= {addr_witdth{1'b0}};
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            wdata_r     <= {reg_width{1'b0}};
            cfg_done_r  <= 1'b0;
            cfg_err_r   <= 1'b0;
            err_code_r  <= 2'd0;
        end else begin
            job_ready_r <= job_ready_nxt_s;
            addr_r      <= addr_nxt_s;
            read_r      <= read_nxt_s;
            write_r     <= write_nxt_s;
            wdata_r     <= wdata_nxt_s;
            cfg_done_r  <= cfg_done_nxt_s;
            cfg_err_r   <= cfg_err_nxt_s;
            err_code_r  <= err_code_nxt_s;
        end
    end

    assign bus.job_ready = job_ready_r;
    assign bus.addr      = addr_r;
    assign bus.read      = read_r;
    assign bus.write     = write_r;
    assign bus.wdata     = wdata_r;
    assign bus.cfg_done  = cfg_done_r;
    assign bus.cfg_err   = cfg_err_r;
    assign bus.err_code  = err_code_r;

endmodule

// File: doc/decryption_cfg_sequencer.md
Name: decryption_cfg_sequencer

Overview:
Job-level controller sitting in front of the decryption register file, on its register access bus (addr/read/write/wdata/rdata/done/error).
Accepts one job descriptor at a time (algorithm + key) and waits for the decryption datapath to drain.
Programs the key register, then the select register, and optionally reads the key back to verify it.
Reports completion or a coded failure, so the host never drives raw register cycles while data is in flight.

Parameters:
addr_witdth, 8, register bus address width
reg_width, 16, register bus data width
SELECT_ADDR, 8'h00, address of mux/demux select register
CAESAR_KEY_ADDR, 8'h10, Caesar key register address
SCYTALE_KEY_ADDR, 8'h12, Scytale key register address ({N,M})
ZIGZAG_KEY_ADDR, 8'h14, Zigzag key register address
TIMEOUT, 16, max cycles waiting for done before abort (>=2)

Ports:
clk_sys  in  1  system clock; only clock in the block
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job descriptor present
job_ready  out  1  sequencer can accept a job
job_alg  in  2  0=Caesar, 1=Scytale, 2=Zigzag, 3=illegal
job_key  in  reg_width  key value for chosen algorithm
dec_busy  in  1  OR of cipher busy flags
addr  out  addr_witdth  register address
read  out  1  register read strobe
write  out  1  register write strobe
wdata  out  reg_width  register write data
rdata  in  reg_width  register read data, valid with done
done  in  1  register access complete
error  in  1  register access failed, valid with done
cfg_done  out  1  one-cycle pulse, job configured OK
cfg_err  out  1  one-cycle pulse, job failed
err_code  out  2  1=illegal alg, 2=bus error/timeout, 3=readback mismatch; held until next job accept

Behaviour:
- Reset (async, immediate): state IDLE; job_ready=1; addr=0, read=0, write=0, wdata=0, cfg_done=0, cfg_err=0, err_code=0. Reset mid-operation abandons any bus access with no further strobes.
- All outputs are registered.
- States: IDLE, DRAIN, WR_KEY, WAIT_KEY, WR_SEL, WAIT_SEL, RD_KEY, WAIT_RD, REPORT.
- IDLE: job_ready=1. A job is accepted when job_valid&job_ready; alg/key are latched, job_ready drops next cycle, err_code is cleared.
- Illegal alg (3): go straight to REPORT with err_code=1 and no bus access.
- DRAIN: wait until dec_busy=0, then WR_KEY. There is no timeout in DRAIN.
- WR_KEY: single-cycle write=1 with addr=key address of the latched alg and wdata=key. Then WAIT_KEY.
- WR_SEL: single-cycle write=1, addr=SELECT_ADDR, wdata={14'b0,alg}. Then WAIT_SEL.
- RD_KEY: single-cycle read=1 with addr=key address. Then WAIT_RD.
- While waiting: addr/wdata are held stable; the strobe is low.
- A timeout counter clears on each strobe and increments each wait cycle. When it reaches TIMEOUT-1 without done, go to REPORT with err_code=2.
- done&error in any wait state → REPORT, err_code=2.
- done&!error: WAIT_KEY→WR_SEL; WAIT_SEL→RD_KEY (or REPORT if readback is compiled out); WAIT_RD→compare rdata to the latched key, mismatch gives err_code=3.
- done arriving in the same cycle as a strobe is ignored; it is only sampled in wait states.
- REPORT: one cycle of cfg_done=1 (err_code=0) or cfg_err=1, then IDLE.
- Key-before-select ordering guarantees the cipher never sees data with a stale key.
- Latency, no-wait bus with done one cycle after the strobe, dec_busy=0: accept at cycle 0, key write at cycle 2, select write at cycle 4, read at cycle 6, cfg_done at cycle 8 (6 without readback).

Optional Feature:
READBACK_VERIFY_EN.
- Defined: RD_KEY/WAIT_RD states exist and err_code=3 is possible.
- Undefined: WAIT_SEL success goes directly to REPORT, read stays 0 permanently, and err_code=3 is never produced.

Test Plan:
1. Reset mid-WAIT_KEY with write just issued → all outputs 0 immediately, job_ready=1 after release, no further strobes.
2. Job alg=0 key=16'h0003, bus done after 1 cycle, dec_busy=0 → write addr 8'h10 wdata 16'h0003, then write addr 8'h00 wdata 16'h0000, read addr 8'h10 returns 16'h0003 → cfg_done pulse at cycle 8, err_code=0.
3. Job alg=1 key=16'h0304 with dec_busy high for 10 cycles → no strobe until dec_busy falls; write to 8'h12 follows 1 cycle later.
4. Job alg=3 → cfg_err at cycle 2, err_code=1, read/write never asserted.
5. Job alg=2, bus never returns done on the key write → cfg_err after TIMEOUT=16 wait cycles, err_code=2; done&error on the select write → err_code=2.
6. READBACK_VERIFY_EN defined, alg=2 key=16'h0005, rdata returns 16'h0004 → cfg_err, err_code=3; with the macro undefined the same stimulus gives cfg_done at cycle 6.
